bidir_channel_port: RTL and testbench
=====================================

Name: bidir_channel_port

Overview:
- Parametrised multi-channel register bank bridging a host register port and a shared bidirectional tri-state bus.
- Each bus transfer either drives one channel's value onto the bus or captures the bus value into a channel.
- A turnaround FSM inserts programmable dead cycles on every direction change, so the block never drives against an external driver.
- Sits at chip/board-facing edges where a narrow shared data bus is time-multiplexed between this block and an external agent.

Parameters:
- WIDTH, 10, data width of each channel and of the bus.
- CHANNELS, 4, number of channel registers (≥1, need not be a power of two).
- TURNAROUND, 1, dead cycles inserted on a bus direction change (0 allowed).
- RESET_VALUE, 0, reset value of every channel register (WIDTH bits).
- localparam CH_W, max(1, clog2(CHANNELS)), channel index width.

Ports:
- i_clk  input  1  clock; all state rises on its positive edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_host_we  input  1  host write strobe.
- i_host_re  input  1  host read strobe.
- i_host_ch  input  CH_W  host channel index.
- i_host_wdata  input  WIDTH  host write data.
- o_host_rdata  output  WIDTH  host read data, registered.
- o_host_rvalid  output  1  pulses the cycle after i_host_re.
- o_host_collision  output  1  pulses when a host write is dropped.
- i_bus_req  input  1  bus transfer request; held until o_bus_ack.
- i_bus_dir  input  1  0 = block drives channel onto bus; 1 = block captures bus into channel.
- i_bus_ch  input  CH_W  bus channel index; stable while i_bus_req is high.
- o_bus_ack  output  1  one-cycle transfer completion pulse.
- o_bus_oe  output  1  high exactly while the block drives io_bus.
- io_bus  inout tri  WIDTH  shared bus; 'z when o_bus_oe=0.

Behaviour:
- Reset (async assert, sync release):
  - All channels = RESET_VALUE.
  - FSM = IDLE; o_bus_oe=0 and io_bus='z immediately, with no clock needed.
  - o_host_rdata=0; o_host_rvalid=0; o_host_collision=0; o_bus_ack=0.
  - last_dir = NONE.
- FSM states:
  - IDLE: on i_bus_req, if last_dir ≠ NONE, last_dir ≠ i_bus_dir and TURNAROUND>0, go to TURN with cnt=TURNAROUND-1. Otherwise go to DRIVE (dir=0) or CAPTURE (dir=1). Direction and channel are latched at this edge.
  - TURN: o_bus_oe=0. While cnt>0, decrement cnt. When cnt==0, go to DRIVE or CAPTURE.
  - DRIVE: o_bus_oe=1, io_bus=reg[ch], o_bus_ack=1, last_dir=0, then return to IDLE.
  - CAPTURE: o_bus_oe=0, reg[ch] <= io_bus at cycle end, o_bus_ack=1, last_dir=1, then return to IDLE.
- Latency from i_bus_req sampled high in IDLE at edge t:
  - ack asserts in cycle t+1 without turnaround, or in cycle t+1+TURNAROUND with turnaround.
  - Minimum 2 cycles per transfer; the requester drops i_bus_req the cycle after ack.
- Host port:
  - Write takes effect at the clock edge.
  - Read returns the pre-edge register value in o_host_rdata the next cycle, with o_host_rvalid=1.
  - Read and write to the same channel in the same cycle returns the old value.
- Collision: a host write and a CAPTURE to the same channel in the same cycle:
  - the bus value wins;
  - the host write is dropped;
  - o_host_collision pulses for one cycle.
  - A host write concurrent with DRIVE of the same channel is not a collision. The bus carries the pre-write value, and the write lands.
- Out-of-range channel (index ≥ CHANNELS):
  - host write ignored; host read returns 0 with rvalid;
  - bus DRIVE puts 0 on io_bus; bus CAPTURE discards data;
  - acks are still generated.
- Reset mid-transfer: the bus is released immediately, no ack is generated, and the next transfer after reset needs no turnaround.
- TURNAROUND=0: the TURN state is unreachable.

Test Plan:
- Reset defaults: assert i_rst, release, then host-read ch0..3 -> each returns RESET_VALUE (0); o_bus_oe=0, io_bus='z.
- Host write then bus drive: host writes ch2=0x155; bus req dir=0 ch2 -> ack at t+1, io_bus=0x155 with oe=1 for exactly that cycle, 'z after.
- Turnaround: drive ch0, then capture ch1 with the external agent driving 0x2AA, TURNAROUND=1 -> one cycle with oe=0 before the CAPTURE ack at t+2; host read ch1 = 0x2AA.
- Collision: CAPTURE ch3 (bus 0x0F0) coincident with host write ch3=0x3FF -> ch3=0x0F0, o_host_collision=1 for one cycle.
- Out-of-range, CHANNELS=3: host write ch3=0x111 ignored; bus drive ch3 -> io_bus=0, ack asserted.
- Reset mid-TURN (TURNAROUND=3): assert i_rst during TURN -> no ack; a subsequent capture acks at t+1 with no turnaround.

Source files
------------

// File: rtl/bidir_channel_port.sv
// Channel register bank bridging a host register port and a shared tri-state bus, with direction-turnaround FSM.
// Host read data 1 cycle; bus ack 1 cycle after req (+TURNAROUND on direction change); requester holds req until ack.
module bidir_channel_port #(
    parameter int WIDTH = 10,
    parameter int CHANNELS = 4,
    parameter int TURNAROUND = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_host_we,
    input  logic              i_host_re,
    input  logic [CH_W-1:0]   i_host_ch,
    input  logic [WIDTH-1:0]  i_host_wdata,
    output logic [WIDTH-1:0]  o_host_rdata,
    output logic              o_host_rvalid,
    output logic              o_host_collision,
    input  logic              i_bus_req,
    input  logic              i_bus_dir,
    input  logic [CH_W-1:0]   i_bus_ch,
    output logic              o_bus_ack,
    output logic              o_bus_oe,
    inout  tri   [WIDTH-1:0]  io_bus
);

    localparam int CNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

    typedef enum logic [1:0] {IDLE, TURN, DRIVE, CAPTURE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              dir;
    logic [CH_W-1:0]   ch;
    logic              last_vld;
    logic              last_dir;
    logic [WIDTH-1:0]  regs [CHANNELS];
    logic [WIDTH-1:0]  drive_dat;
    logic [WIDTH-1:0]  host_rd;

    // Out-of-range indices match no channel and therefore read as zero.
    always_comb begin
        drive_dat = '0;
        host_rd   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CH_W'(i))        drive_dat = regs[i];
            if (i_host_ch == CH_W'(i)) host_rd   = regs[i];
        end
    end

    assign io_bus = o_bus_oe ? drive_dat : {WIDTH{1'bz}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dir       <= 1'b0;
            ch        <= '0;
            last_vld  <= 1'b0;
            last_dir  <= 1'b0;
            o_bus_oe  <= 1'b0;
            o_bus_ack <= 1'b0;
        end else begin
            o_bus_oe  <= 1'b0;
            o_bus_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_bus_req) begin
                        dir <= i_bus_dir;
                        ch  <= i_bus_ch;
                        if (TURNAROUND > 0 && last_vld && last_dir != i_bus_dir) begin
                            state <= TURN;
                            cnt   <= CNT_W'(TURNAROUND - 1);
                        end else begin
                            state     <= i_bus_dir ? CAPTURE : DRIVE;
                            o_bus_oe  <= ~i_bus_dir;
                            o_bus_ack <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= dir ? CAPTURE : DRIVE;
                        o_bus_oe  <= ~dir;
                        o_bus_ack <= 1'b1;
                    end
                end
                DRIVE, CAPTURE: begin
                    state    <= IDLE;
                    last_vld <= 1'b1;
                    last_dir <= dir;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A capture owns its channel for the cycle; a same-channel host write is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < CHANNELS; i++) regs[i] <= RESET_VALUE;
            o_host_rdata     <= '0;
            o_host_rvalid    <= 1'b0;
            o_host_collision <= 1'b0;
        end else begin
            o_host_rvalid    <= i_host_re;
            o_host_collision <= 1'b0;
            if (i_host_re) o_host_rdata <= host_rd;
            for (int i = 0; i < CHANNELS; i++) begin
                if (state == CAPTURE && ch == CH_W'(i))
                    regs[i] <= io_bus;
                else if (i_host_we && i_host_ch == CH_W'(i))
                    regs[i] <= i_host_wdata;
            end
            if (state == CAPTURE && i_host_we && i_host_ch == ch && {1'b0, ch} < CH_LIM)
                o_host_collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bidir_channel_port.sv
// Bench for bidir_channel_port: instance 0 uses defaults, instance 1 has CHANNELS=3, TURNAROUND=3.
module tb_bidir_channel_port;

    logic        clk;
    logic [1:0]  rst;
    logic [1:0]  we, re, req, dir, ack, oe, rvalid, coll, ag_en;
    logic [1:0]  hch;
    logic [9:0]  hwd;
    logic [1:0]  bch0, bch1;
    logic [9:0]  ag_val;
    logic [1:0][9:0] rdata;
    tri   [9:0]  bus0, bus1;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    assign bus0 = ag_en[0] ? ag_val : 10'bz;
    assign bus1 = ag_en[1] ? ag_val : 10'bz;

    bidir_channel_port #(.WIDTH(10), .CHANNELS(4), .TURNAROUND(1)) u_a (
        .i_clk(clk), .i_rst(rst[0]),
        .i_host_we(we[0]), .i_host_re(re[0]), .i_host_ch(hch), .i_host_wdata(hwd),
        .o_host_rdata(rdata[0]), .o_host_rvalid(rvalid[0]), .o_host_collision(coll[0]),
        .i_bus_req(req[0]), .i_bus_dir(dir[0]), .i_bus_ch(bch0),
        .o_bus_ack(ack[0]), .o_bus_oe(oe[0]), .io_bus(bus0)
    );

    bidir_channel_port #(.WIDTH(10), .CHANNELS(3), .TURNAROUND(3)) u_b (
        .i_clk(clk), .i_rst(rst[1]),
        .i_host_we(we[1]), .i_host_re(re[1]), .i_host_ch(hch), .i_host_wdata(hwd),
        .o_host_rdata(rdata[1]), .o_host_rvalid(rvalid[1]), .o_host_collision(coll[1]),
        .i_bus_req(req[1]), .i_bus_dir(dir[1]), .i_bus_ch(bch1),
        .o_bus_ack(ack[1]), .o_bus_oe(oe[1]), .io_bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; any read issued before this edge must return now.
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("a_rvalid", {31'b0, rvalid[0]}, 1);
            check("a_rdata", {22'b0, rdata[0]}, {22'b0, e});
        end else begin
            check("a_rvalid_idle", {31'b0, rvalid[0]}, 0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("b_rvalid", {31'b0, rvalid[1]}, 1);
            check("b_rdata", {22'b0, rdata[1]}, {22'b0, e});
        end else begin
            check("b_rvalid_idle", {31'b0, rvalid[1]}, 0);
        end
    endtask

    task automatic host(input int i, input logic w, input logic r, input logic [1:0] ch,
                        input logic [9:0] wd, input logic [9:0] exp);
        we[i] = w;
        re[i] = r;
        hch = ch;
        hwd = wd;
        if (r) begin
            if (i == 0) q0.push_back(exp);
            else        q1.push_back(exp);
        end
        tick();
        we[i] = 1'b0;
        re[i] = 1'b0;
    endtask

    task automatic set_bch(input int i, input logic [1:0] ch);
        if (i == 0) bch0 = ch;
        else        bch1 = ch;
    endtask

    task automatic bus_xfer(input int i, input logic d, input logic [1:0] ch, input logic [9:0] agv,
                            input int exp_lat, input logic [9:0] exp_bus, input string nm);
        int lat;
        logic got;
        req[i] = 1'b1;
        dir[i] = d;
        set_bch(i, ch);
        ag_val = agv;
        ag_en[i] = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if (ack[i]) got = 1'b1;
            else check({nm, "_wait_oe"}, {31'b0, oe[i]}, 0);
        end
        check({nm, "_ack_lat"}, got ? lat : 99, exp_lat);
        if (got) begin
            check({nm, "_oe"}, {31'b0, oe[i]}, {31'b0, ~d});
            if (!d) check({nm, "_bus"}, {22'b0, (i != 0) ? bus1 : bus0}, {22'b0, exp_bus});
        end
        req[i] = 1'b0;
        tick();
        ag_en[i] = 1'b0;
        check({nm, "_ack_off"}, {31'b0, ack[i]}, 0);
        check({nm, "_oe_off"}, {31'b0, oe[i]}, 0);
    endtask

    typedef struct {
        int         inst;
        logic       w;
        logic       r;
        logic [1:0] ch;
        logic [9:0] wd;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000};
        tbl[1]  = '{0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000};
        tbl[2]  = '{0, 1'b0, 1'b1, 2'd2, 10'h000, 10'h000};
        tbl[3]  = '{0, 1'b0, 1'b1, 2'd3, 10'h000, 10'h000};
        tbl[4]  = '{0, 1'b1, 1'b0, 2'd2, 10'h155, 10'h000};
        tbl[5]  = '{0, 1'b0, 1'b1, 2'd2, 10'h000, 10'h155};
        tbl[6]  = '{0, 1'b1, 1'b1, 2'd0, 10'h3C3, 10'h000};
        tbl[7]  = '{0, 1'b0, 1'b1, 2'd0, 10'h000, 10'h3C3};
        tbl[8]  = '{0, 1'b1, 1'b0, 2'd1, 10'h077, 10'h000};
        tbl[9]  = '{0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h077};
        tbl[10] = '{1, 1'b1, 1'b0, 2'd3, 10'h111, 10'h000};
        tbl[11] = '{1, 1'b0, 1'b1, 2'd3, 10'h000, 10'h000};
        tbl[12] = '{1, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000};
        tbl[13] = '{1, 1'b1, 1'b0, 2'd2, 10'h222, 10'h000};
        tbl[14] = '{1, 1'b0, 1'b1, 2'd2, 10'h000, 10'h222};
        tbl[15] = '{1, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000};

        rst = 2'b11;
        we = '0; re = '0; req = '0; dir = '0; ag_en = '0;
        hch = '0; hwd = '0; bch0 = '0; bch1 = '0; ag_val = '0;
        #1;
        check("rst_oe_async", {30'b0, oe}, 0);
        tick();
        tick();
        check("rst_ack", {30'b0, ack}, 0);
        check("rst_coll", {30'b0, coll}, 0);
        check("rst_rdata_a", {22'b0, rdata[0]}, 0);
        check("rst_rdata_b", {22'b0, rdata[1]}, 0);
        rst = 2'b00;
        tick();

        for (int k = 0; k < 16; k++)
            host(tbl[k].inst, tbl[k].w, tbl[k].r, tbl[k].ch, tbl[k].wd, tbl[k].exp);

        // Instance 0: drives, turnaround into capture
        bus_xfer(0, 1'b0, 2'd2, 10'h000, 1, 10'h155, "drv2");
        bus_xfer(0, 1'b0, 2'd0, 10'h000, 1, 10'h3C3, "drv0");
        bus_xfer(0, 1'b1, 2'd1, 10'h2AA, 2, 10'h000, "cap1_turn");
        host(0, 1'b0, 1'b1, 2'd1, 10'h000, 10'h2AA);

        // Capture ch3 colliding with a host write in the capture cycle
        req[0] = 1'b1; dir[0] = 1'b1; bch0 = 2'd3; ag_val = 10'h0F0; ag_en[0] = 1'b1;
        tick();
        check("col_ack", {31'b0, ack[0]}, 1);
        req[0] = 1'b0; we[0] = 1'b1; hch = 2'd3; hwd = 10'h3FF;
        tick();
        we[0] = 1'b0; ag_en[0] = 1'b0;
        check("col_pulse", {31'b0, coll[0]}, 1);
        check("col_ack_off", {31'b0, ack[0]}, 0);
        tick();
        check("col_pulse_off", {31'b0, coll[0]}, 0);
        host(0, 1'b0, 1'b1, 2'd3, 10'h000, 10'h0F0);

        // Drive ch2 (turnaround after capture) with a same-channel host write: not a collision
        req[0] = 1'b1; dir[0] = 1'b0; bch0 = 2'd2;
        tick();
        check("dw_turn_ack", {31'b0, ack[0]}, 0);
        check("dw_turn_oe", {31'b0, oe[0]}, 0);
        tick();
        check("dw_ack", {31'b0, ack[0]}, 1);
        check("dw_oe", {31'b0, oe[0]}, 1);
        req[0] = 1'b0; we[0] = 1'b1; hch = 2'd2; hwd = 10'h0AB;
        #1;
        check("dw_bus_prewrite", {22'b0, bus0}, 10'h155);
        tick();
        we[0] = 1'b0;
        check("dw_no_coll", {31'b0, coll[0]}, 0);
        check("dw_oe_off", {31'b0, oe[0]}, 0);
        host(0, 1'b0, 1'b1, 2'd2, 10'h000, 10'h0AB);

        // Async reset while driving releases the bus without a clock
        req[0] = 1'b1; dir[0] = 1'b0; bch0 = 2'd0;
        tick();
        check("ar_oe_before", {31'b0, oe[0]}, 1);
        rst[0] = 1'b1;
        #1;
        check("ar_oe_released", {31'b0, oe[0]}, 0);
        check("ar_ack_cleared", {31'b0, ack[0]}, 0);
        req[0] = 1'b0;
        tick();
        rst[0] = 1'b0;

        // Instance 1: out-of-range channel on the bus
        bus_xfer(1, 1'b0, 2'd3, 10'h000, 1, 10'h000, "oor_drv");
        bus_xfer(1, 1'b1, 2'd3, 10'h155, 4, 10'h000, "oor_cap_turn3");
        host(1, 1'b0, 1'b1, 2'd0, 10'h000, 10'h000);
        host(1, 1'b0, 1'b1, 2'd1, 10'h000, 10'h000);
        host(1, 1'b0, 1'b1, 2'd2, 10'h000, 10'h222);

        // Reset in the middle of a turnaround
        req[1] = 1'b1; dir[1] = 1'b0; bch1 = 2'd2;
        tick();
        tick();
        check("mt_ack_turn", {31'b0, ack[1]}, 0);
        check("mt_oe_turn", {31'b0, oe[1]}, 0);
        rst[1] = 1'b1;
        #1;
        check("mt_oe_rst", {31'b0, oe[1]}, 0);
        req[1] = 1'b0;
        tick();
        check("mt_ack_rst", {31'b0, ack[1]}, 0);
        rst[1] = 1'b0;
        tick();
        check("mt_ack_after", {31'b0, ack[1]}, 0);
        tick();
        check("mt_ack_after2", {31'b0, ack[1]}, 0);
        bus_xfer(1, 1'b1, 2'd1, 10'h0CC, 1, 10'h000, "post_rst_cap");
        host(1, 1'b0, 1'b1, 2'd1, 10'h000, 10'h0CC);
        host(1, 1'b0, 1'b1, 2'd2, 10'h000, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
